// File: rtl/apb_sram_arb_if.sv
// Requester handshake and APB master bus bundle for apb_sram_arb.
// master = arbiter side, slave = requesters plus SRAM slave side.
interface apb_sram_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rdata;
  logic                      psel;
  logic                      penable;
  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;

  modport master (
    input  req, req_write, req_addr, req_wdata, prdata, pready,
    output done, err, rdata, psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, prdata, pready,
    input  done, err, rdata, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_sram_arb.sv
// Round-robin arbiter + APB master sharing one APB SRAM slave between NUM_REQ requesters.
// Optional ACCESS watchdog enabled by defining APB_SRAM_ARB_TIMEOUT_EN.
module apb_sram_arb #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  apb_sram_arb_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("apb_sram_arb: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    rr_ptr;
  logic                psel_q;
  logic                penable_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_c;
  logic [IDX_W-1:0]    pick_c;
  logic [IDX_W-1:0]    idx_c;
  logic [ADDR_W-1:0]   addr_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                complete_c;
  logic                timeout_c;
  logic                finish_c;
  logic [IDX_W-1:0]    next_ptr_c;
  logic [NUM_REQ-1:0]  done_c;

  // First set req bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_c  = 1'b0;
    pick_c = rr_ptr;
    idx_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_c && bus.req[idx_c]) begin
        any_c  = 1'b1;
        pick_c = idx_c;
      end
    end
  end

  assign addr_c     = bus.req_addr[32'(pick_c)*ADDR_W +: ADDR_W];
  assign wdata_c    = bus.req_wdata[32'(pick_c)*DATA_W +: DATA_W];
  assign complete_c = (state == ACCESS) && bus.pready;
  assign finish_c   = complete_c || timeout_c;
  assign next_ptr_c = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);

`ifdef APB_SRAM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Fires on the ACCESS cycle whose increment would reach TIMEOUT_CYC; pready wins.
  assign timeout_c = (state == ACCESS) && !bus.pready && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !bus.pready) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    done_c = '0;
    if (finish_c) begin
      done_c[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      winner    <= '0;
      rr_ptr    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_c) begin
            winner   <= pick_c;
            paddr_q  <= addr_c;
            pwrite_q <= bus.req_write[pick_c];
            pwdata_q <= wdata_c;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (finish_c) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rr_ptr    <= next_ptr_c;
            state     <= IDLE;
            if (complete_c && !pwrite_q) begin
              rdata_q <= bus.prdata;
            end
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.done    = done_c;
  assign bus.err     = timeout_c;
  assign bus.rdata   = rdata_q;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_sram_arb.sv
// Directed self-checking bench for apb_sram_arb: a 2-requester instance on a small
// SRAM model with stall control, plus a 4-requester instance for fairness.
module tb_apb_sram_arb;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic [DW-1:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_sram_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  apb_sram_arb_if #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW)) bus4 ();

  apb_sram_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  apb_sram_arb #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  // Word-addressed SRAM model; stall holds pready low.
  assign bus.pready  = !stall;
  assign bus.prdata  = mem[bus.paddr[5:2]];
  assign bus4.pready = 1'b1;
  assign bus4.prdata = '0;

  always @(posedge clk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite) mem[bus.paddr[5:2]] <= bus.pwdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_write[i]         = w;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req[i]               = 1'b1;
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    d = '0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus.done !== '0) begin
        d = bus.done;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin errors++; $display("FAIL reset_psel: psel=%b penable=%b want 0 0", bus.psel, bus.penable); end
    checks++; if (bus.paddr !== 12'h0 || bus.pwdata !== 32'h0 || bus.pwrite !== 1'b0) begin errors++; $display("FAIL reset_bus: paddr=%h pwdata=%h pwrite=%b want 0", bus.paddr, bus.pwdata, bus.pwrite); end
    checks++; if (bus.rdata !== 32'h0 || bus.done !== 2'b00 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_out: rdata=%h done=%b err=%b want 0", bus.rdata, bus.done, bus.err); end
  endtask

  task automatic test_single_write;
    set_req(0, 1'b1, 12'h010, 32'hDEADBEEF);
    checks++; if (bus.psel !== 1'b0) begin errors++; $display("FAIL wr_idle_psel: got %b want 0", bus.psel); end
    tick();
    checks++; if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.done !== 2'b00) begin errors++; $display("FAIL wr_setup: psel=%b penable=%b done=%b want 1 0 00", bus.psel, bus.penable, bus.done); end
    checks++; if (bus.paddr !== 12'h010 || bus.pwdata !== 32'hDEADBEEF || bus.pwrite !== 1'b1) begin errors++; $display("FAIL wr_setup_bus: paddr=%h pwdata=%h pwrite=%b want 010 deadbeef 1", bus.paddr, bus.pwdata, bus.pwrite); end
    bus.req_addr[0 +: AW]  = 12'h3FC;
    bus.req_wdata[0 +: DW] = 32'h0;
    tick();
    checks++; if (bus.penable !== 1'b1 || bus.done !== 2'b01) begin errors++; $display("FAIL wr_access: penable=%b done=%b want 1 01", bus.penable, bus.done); end
    checks++; if (bus.paddr !== 12'h010 || bus.pwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_stable: paddr=%h pwdata=%h want 010 deadbeef", bus.paddr, bus.pwdata); end
    tick();
    bus.req[0] = 1'b0;
    checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.done !== 2'b00) begin errors++; $display("FAIL wr_after: psel=%b penable=%b done=%b want 0 0 00", bus.psel, bus.penable, bus.done); end
    checks++; if (mem[4] !== 32'hDEADBEEF || bus.paddr !== 12'h010) begin errors++; $display("FAIL wr_mem: mem=%h paddr=%h want deadbeef 010", mem[4], bus.paddr); end
  endtask

  task automatic test_write_read;
    logic [N-1:0] d;
    set_req(1, 1'b1, 12'h020, 32'hA5A50001);
    wait_done(d);
    checks++; if (d !== 2'b10) begin errors++; $display("FAIL wr1_done: got %b want 10", d); end
    tick();
    set_req(1, 1'b0, 12'h020, 32'h0);
    wait_done(d);
    checks++; if (d !== 2'b10 || bus.pwrite !== 1'b0 || bus.paddr !== 12'h020) begin errors++; $display("FAIL rd1_done: done=%b pwrite=%b paddr=%h want 10 0 020", d, bus.pwrite, bus.paddr); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rd1_early: rdata=%h want 0", bus.rdata); end
    tick();
    bus.req[1] = 1'b0;
    checks++; if (bus.rdata !== 32'hA5A50001) begin errors++; $display("FAIL rd1_data: rdata=%h want a5a50001", bus.rdata); end
  endtask

  task automatic test_contention;
    logic [N-1:0] d;
    logic [N-1:0] exp_seq [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 1'b1, 12'h030, 32'h11);
    set_req(1, 1'b1, 12'h034, 32'h22);
    for (int k = 0; k < 4; k++) begin
      wait_done(d);
      checks++; if (d !== exp_seq[k]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, d, exp_seq[k]); end
      tick();
      checks++; if (bus.psel !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: psel=%b want 0", k, bus.psel); end
    end
    bus.req[0] = 1'b0;
    wait_done(d);
    checks++; if (d !== 2'b10) begin errors++; $display("FAIL rr_only1: got %b want 10", d); end
    tick();
    bus.req = '0;
  endtask

  task automatic test_reset_mid_access;
    logic [N-1:0] d;
    logic seen;
    set_req(0, 1'b1, 12'h040, 32'h55);
    wait_done(d);
    checks++; if (d !== 2'b01) begin errors++; $display("FAIL pre_rst_grant: got %b want 01", d); end
    tick();
    bus.req[0] = 1'b0;
    stall = 1'b1;
    set_req(1, 1'b0, 12'h020, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.penable === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1 || bus.done !== 2'b00) begin errors++; $display("FAIL stall_access: penable_seen=%b done=%b want 1 00", seen, bus.done); end
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.done !== 2'b00) begin errors++; $display("FAIL mid_rst: psel=%b penable=%b done=%b want 0 0 00", bus.psel, bus.penable, bus.done); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: rdata=%h want 0", bus.rdata); end
    set_req(0, 1'b1, 12'h044, 32'h66);
    set_req(1, 1'b1, 12'h048, 32'h77);
    wait_done(d);
    checks++; if (d !== 2'b01) begin errors++; $display("FAIL mid_rst_ptr: got %b want 01", d); end
    tick();
    bus.req = '0;
  endtask

`ifdef APB_SRAM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    // rr_ptr is 1 here, so requester 1 is served; mem[8] holds a5a50001.
    stall = 1'b1;
    set_req(1, 1'b0, 12'h020, 32'h0);
    tick();
    tick();
    checks++; if (bus.penable !== 1'b1 || bus.done !== 2'b00 || bus.err !== 1'b0) begin errors++; $display("FAIL to_acc1: penable=%b done=%b err=%b want 1 00 0", bus.penable, bus.done, bus.err); end
    tick();
    tick();
    checks++; if (bus.done !== 2'b00 || bus.err !== 1'b0) begin errors++; $display("FAIL to_acc3: done=%b err=%b want 00 0", bus.done, bus.err); end
    tick();
    checks++; if (bus.done !== 2'b10 || bus.err !== 1'b1) begin errors++; $display("FAIL to_fire: done=%b err=%b want 10 1", bus.done, bus.err); end
    tick();
    bus.req = '0;
    checks++; if (bus.psel !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL to_after: psel=%b err=%b rdata=%h want 0 0 0", bus.psel, bus.err, bus.rdata); end
    set_req(0, 1'b0, 12'h020, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    stall = 1'b0;
    #1;
    checks++; if (bus.done !== 2'b01 || bus.err !== 1'b0) begin errors++; $display("FAIL to_prio: done=%b err=%b want 01 0", bus.done, bus.err); end
    tick();
    bus.req = '0;
    checks++; if (bus.rdata !== 32'hA5A50001) begin errors++; $display("FAIL to_prio_rdata: rdata=%h want a5a50001", bus.rdata); end
  endtask
`else
  task automatic test_no_timeout;
    logic quiet;
    stall = 1'b1;
    set_req(1, 1'b0, 12'h020, 32'h0);
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done !== 2'b00 || bus.err !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1 || bus.penable !== 1'b1) begin errors++; $display("FAIL wait_forever: quiet=%b penable=%b want 1 1", quiet, bus.penable); end
    stall = 1'b0;
    #1;
    checks++; if (bus.done !== 2'b10 || bus.err !== 1'b0) begin errors++; $display("FAIL late_ready: done=%b err=%b want 10 0", bus.done, bus.err); end
    tick();
    bus.req = '0;
    checks++; if (bus.rdata !== 32'hA5A50001) begin errors++; $display("FAIL late_rdata: rdata=%h want a5a50001", bus.rdata); end
  endtask
`endif

  task automatic test_back_to_back;
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus4.req_write = 4'b1111;
    bus4.req       = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus4.done !== 4'b0000) break;
      end
      checks++; if (bus4.done !== exp_seq[k]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, bus4.done, exp_seq[k]); end
      tick();
      checks++; if (bus4.psel !== 1'b0) begin errors++; $display("FAIL fair_gap%0d: psel=%b want 0", k, bus4.psel); end
    end
    bus4.req = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst            = 1'b1;
    stall          = 1'b0;
    bus.req        = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus4.req       = '0;
    bus4.req_write = '0;
    bus4.req_addr  = {12'h00C, 12'h008, 12'h004, 12'h000};
    bus4.req_wdata = '0;
    test_reset();
    test_single_write();
    test_write_read();
    test_contention();
    test_reset_mid_access();
`ifdef APB_SRAM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
